// File: rtl/fetch_bundle_issuer.sv
// Fetch-side producer: issues sequential line requests to the ICache, queues the
// returned lines and presents predecoded two-lane bundles to the instruction buffer.
module fetch_bundle_issuer #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic        req_valid,
   output logic [31:0] req_pc,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [63:0] resp_data,
   input  logic        ib_pause,
   output logic        inst0_valid,
   output logic        inst1_valid,
   output logic [31:0] inst0_pc,
   output logic [31:0] inst1_pc,
   output logic [31:0] inst0_inst,
   output logic [31:0] inst1_inst,
   output logic        inst0_isJ,
   output logic        inst1_isJ,
   output logic        inst0_isBr,
   output logic        inst1_isBr
);
   localparam int            PW        = $clog2(QDEPTH);
   localparam int            NUM_LANES = 2;
   localparam logic [PW+1:0] QD        = (PW+2)'(QDEPTH);
   localparam logic [PW:0]   ONE       = (PW+1)'(1);

   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] data;
   } qEntry_t;

   qEntry_t     queue  [QDEPTH];
   logic [31:0] pcFifo [QDEPTH];
   logic [PW:0] qWr, qRd, fWr, fRd;
   logic [PW:0] outstanding, dropCnt, qCount;
   logic [31:0] pc;
   logic        started;
   logic        qEmpty, qFull, reqFire, push, pop;
   qEntry_t     head;

   assign qCount = qWr - qRd;
   assign qEmpty = (qWr == qRd);
   assign qFull  = (qWr[PW] != qRd[PW]) && (qWr[PW-1:0] == qRd[PW-1:0]);

   // Credits cover both in-flight requests and queued lines, so the queue never overflows.
   assign req_valid = started && !flush && (({1'b0, outstanding} + {1'b0, qCount}) < QD);
   assign req_pc    = pc;
   assign reqFire   = req_valid && req_ready;
   assign push      = resp_valid && !flush && (dropCnt == '0);
   assign pop       = !flush && !qEmpty && !ib_pause;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         started     <= 1'b0;
         outstanding <= '0;
         dropCnt     <= '0;
         qWr         <= '0;
         qRd         <= '0;
         fWr         <= '0;
         fRd         <= '0;
      end else begin
         started     <= 1'b1;
         outstanding <= outstanding + (PW+1)'(reqFire) - (PW+1)'(resp_valid);
         if (flush) begin
            // Everything still in flight belongs to the old path, including a same-cycle response.
            pc      <= flush_target;
            dropCnt <= outstanding - (PW+1)'(resp_valid);
            qWr     <= '0;
            qRd     <= '0;
            fWr     <= '0;
            fRd     <= '0;
         end else begin
            if (reqFire) begin
               pc  <= {pc[31:3], 3'b000} + 32'd8;
               fWr <= fWr + ONE;
            end
            if (resp_valid && (dropCnt != '0))
               dropCnt <= dropCnt - ONE;
            if (push) begin
               qWr <= qWr + ONE;
               fRd <= fRd + ONE;
            end
            if (pop)
               qRd <= qRd + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reqFire)
         pcFifo[fWr[PW-1:0]] <= pc;
      if (push)
         queue[qWr[PW-1:0]] <= '{pc: pcFifo[fRd[PW-1:0]], data: resp_data};
   end

   assert property (@(posedge clk) disable iff (rst) !(push && qFull && !pop))
      else $error("response queue overflow");

   logic [NUM_LANES-1:0]       laneValid, laneJ, laneBr;
   logic [NUM_LANES-1:0][31:0] lanePc, laneInst;

   assign head      = queue[qRd[PW-1:0]];
   // A redirect into the upper word of a line leaves lane0 empty.
   assign laneValid = {!qEmpty, !qEmpty && !head.pc[2]};

   generate
      for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
         logic [5:0] op, fn;
         assign lanePc[i]   = (head.pc & 32'hFFFF_FFF8) + 32'(4 * i);
         assign laneInst[i] = head.data[32*i +: 32];
         assign op          = laneInst[i][31:26];
         assign fn          = laneInst[i][5:0];

         always_comb begin
            laneJ[i]  = 1'b0;
            laneBr[i] = 1'b0;
            if (laneValid[i]) begin
               case (op)
                  6'b000000: laneJ[i] = (fn == 6'b001000) || (fn == 6'b001001);
                  6'b000010, 6'b000011: laneJ[i] = 1'b1;
                  6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: laneBr[i] = 1'b1;
                  default: ;
               endcase
            end
         end
      end
   endgenerate

   assign inst0_valid = laneValid[0];
   assign inst1_valid = laneValid[1];
   assign inst0_pc    = lanePc[0];
   assign inst1_pc    = lanePc[1];
   assign inst0_inst  = laneInst[0];
   assign inst1_inst  = laneInst[1];
   assign inst0_isJ   = laneJ[0];
   assign inst1_isJ   = laneJ[1];
   assign inst0_isBr  = laneBr[0];
   assign inst1_isBr  = laneBr[1];

endmodule

// File: tb/tb_fetch_bundle_issuer.sv
// Directed bench for fetch_bundle_issuer with a latency-1 in-order ICache model.
module tb_fetch_bundle_issuer;
   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, req_ready = 1'b0;
   logic        resp_valid = 1'b0, ib_pause = 1'b0;
   logic [31:0] flush_target = 32'h0;
   logic [63:0] resp_data = 64'h0;
   logic        req_valid, inst0_valid, inst1_valid;
   logic [31:0] req_pc, inst0_pc, inst1_pc, inst0_inst, inst1_inst;
   logic        inst0_isJ, inst1_isJ, inst0_isBr, inst1_isBr;

   int nCmp = 0, nBad = 0;

   fetch_bundle_issuer dut (
      .clk(clk), .rst(rst), .flush(flush), .flush_target(flush_target),
      .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .ib_pause(ib_pause),
      .inst0_valid(inst0_valid), .inst1_valid(inst1_valid),
      .inst0_pc(inst0_pc), .inst1_pc(inst1_pc),
      .inst0_inst(inst0_inst), .inst1_inst(inst1_inst),
      .inst0_isJ(inst0_isJ), .inst1_isJ(inst1_isJ),
      .inst0_isBr(inst0_isBr), .inst1_isBr(inst1_isBr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      case (a)
         32'h8000_0100: word = 32'h0800_0000;   // j
         32'h8000_0104: word = 32'h1000_0000;   // beq
         32'h8000_0200: word = 32'h03E0_0008;   // jr ra
         32'h8000_0204: word = 32'h0C00_0010;   // jal
         default:       word = {16'h2000, a[15:0]};
      endcase
   endfunction

   // ICache model: requests sampled just before the edge, answered in order one cycle later.
   logic        icEn = 1'b0, acc, rv;
   logic [31:0] accPc;
   logic [31:0] icQ[$];
   initial forever begin
      @(negedge clk); #4;
      acc   = !rst && req_valid && req_ready;
      accPc = req_pc;
      rv    = resp_valid;
      @(posedge clk);
      if (rst) icQ.delete();
      else begin
         if (rv && icQ.size() > 0) void'(icQ.pop_front());
         if (acc) icQ.push_back(accPc & 32'hFFFF_FFF8);
      end
      #2;
      if (icEn && !rst && icQ.size() > 0) begin
         resp_valid = 1'b1;
         resp_data  = {word(icQ[0] + 32'd4), word(icQ[0])};
      end else
         resp_valid = 1'b0;
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic waitBundle(output bit got);
      got = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (inst1_valid) begin got = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      tick(); tick();
      nCmp++; if (req_valid !== 1'b0) begin nBad++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
      nCmp++; if (req_pc !== 32'hBFC0_0000) begin nBad++; $display("FAIL rst_req_pc got %h want bfc00000", req_pc); end
      nCmp++; if ({inst0_valid, inst1_valid} !== 2'b00) begin nBad++; $display("FAIL rst_lane_valid got %b want 00", {inst0_valid, inst1_valid}); end
      rst = 1'b0; req_ready = 1'b1; icEn = 1'b1;
      #1;
      nCmp++; if (req_valid !== 1'b0) begin nBad++; $display("FAIL release_req_valid got %b want 0", req_valid); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp [3] = '{32'hBFC0_0000, 32'hBFC0_0008, 32'hBFC0_0010};
      for (int i = 0; i < 3; i++) begin
         tick();
         nCmp++; if (req_valid !== 1'b1 || req_pc !== exp[i]) begin nBad++; $display("FAIL seq_req_pc%0d got %b/%h want 1/%h", i, req_valid, req_pc, exp[i]); end
      end
      nCmp++; if ({inst0_valid, inst1_valid} !== 2'b11) begin nBad++; $display("FAIL seq_valid got %b want 11", {inst0_valid, inst1_valid}); end
      nCmp++; if (inst0_pc !== 32'hBFC0_0000 || inst1_pc !== 32'hBFC0_0004) begin nBad++; $display("FAIL seq_pcs got %h/%h want bfc00000/bfc00004", inst0_pc, inst1_pc); end
      nCmp++; if (inst0_inst !== 32'h2000_0000 || inst1_inst !== 32'h2000_0004) begin nBad++; $display("FAIL seq_inst got %h/%h want 20000000/20000004", inst0_inst, inst1_inst); end
   endtask

   task automatic test_flush_drop();
      bit got;
      rst = 1'b1; req_ready = 1'b0; icEn = 1'b0;
      #1;
      nCmp++; if (req_valid !== 1'b0 || {inst0_valid, inst1_valid} !== 2'b00) begin nBad++; $display("FAIL midrst got %b/%b want 0/00", req_valid, {inst0_valid, inst1_valid}); end
      tick(); rst = 1'b0;
      tick(); req_ready = 1'b1;
      tick(); tick(); tick();          // three requests accepted, none answered
      flush = 1'b1; flush_target = 32'h8000_0104; icEn = 1'b1;
      #1;
      nCmp++; if (req_valid !== 1'b0) begin nBad++; $display("FAIL flush_cycle_req got %b want 0", req_valid); end
      tick(); flush = 1'b0;
      #1;
      nCmp++; if (inst1_valid !== 1'b0 || req_pc !== 32'h8000_0104) begin nBad++; $display("FAIL post_flush got %b/%h want 0/80000104", inst1_valid, req_pc); end
      waitBundle(got);
      nCmp++; if (!got) begin nBad++; $display("FAIL flush_bundle_timeout got none want bundle"); end
      nCmp++; if (inst0_valid !== 1'b0 || inst1_pc !== 32'h8000_0104) begin nBad++; $display("FAIL flush_bundle got %b/%h want 0/80000104", inst0_valid, inst1_pc); end
      nCmp++; if (inst1_isBr !== 1'b1 || inst1_inst !== 32'h1000_0000) begin nBad++; $display("FAIL flush_beq got %b/%h want 1/10000000", inst1_isBr, inst1_inst); end
      nCmp++; if (inst0_isJ !== 1'b0) begin nBad++; $display("FAIL invalid_lane_isJ got %b want 0", inst0_isJ); end
   endtask

   task automatic test_predecode();
      bit got;
      flush = 1'b1; flush_target = 32'h8000_0200;
      tick(); flush = 1'b0;
      nCmp++; if ({inst0_valid, inst1_valid} !== 2'b00) begin nBad++; $display("FAIL pd_after_flush got %b want 00", {inst0_valid, inst1_valid}); end
      waitBundle(got);
      nCmp++; if (!got || inst0_valid !== 1'b1 || inst0_pc !== 32'h8000_0200) begin nBad++; $display("FAIL pd_bundle got %b/%b/%h want 1/1/80000200", got, inst0_valid, inst0_pc); end
      nCmp++; if ({inst0_isJ, inst1_isJ} !== 2'b11) begin nBad++; $display("FAIL pd_isJ got %b want 11", {inst0_isJ, inst1_isJ}); end
      nCmp++; if ({inst0_isBr, inst1_isBr} !== 2'b00) begin nBad++; $display("FAIL pd_isBr got %b want 00", {inst0_isBr, inst1_isBr}); end
   endtask

   task automatic test_pause();
      bit got;
      flush = 1'b1; flush_target = 32'h0000_0010;
      tick(); flush = 1'b0;
      waitBundle(got);
      ib_pause = 1'b1;
      nCmp++; if (!got || inst0_pc !== 32'h10) begin nBad++; $display("FAIL pause_first got %b/%h want 1/00000010", got, inst0_pc); end
      for (int i = 0; i < 5; i++) begin
         tick();
         nCmp++; if (inst0_valid !== 1'b1 || inst0_pc !== 32'h10 || inst1_inst !== 32'h2000_0014) begin nBad++; $display("FAIL pause_hold%0d got %b/%h/%h want 1/00000010/20000014", i, inst0_valid, inst0_pc, inst1_inst); end
      end
      nCmp++; if (req_valid !== 1'b0) begin nBad++; $display("FAIL pause_credit got %b want 0", req_valid); end
   endtask

   task automatic test_simultaneous();
      ib_pause = 1'b0;
      tick();                          // pop: three left, credit frees
      nCmp++; if (inst0_pc !== 32'h18 || req_valid !== 1'b1 || req_pc !== 32'h30) begin nBad++; $display("FAIL sim_pop got %h/%b/%h want 00000018/1/00000030", inst0_pc, req_valid, req_pc); end
      ib_pause = 1'b1;
      tick();                          // request accepted while held
      nCmp++; if (inst0_pc !== 32'h18 || req_valid !== 1'b0) begin nBad++; $display("FAIL sim_hold got %h/%b want 00000018/0", inst0_pc, req_valid); end
      ib_pause = 1'b0;
      tick();                          // push and pop with three queued
      nCmp++; if (inst0_pc !== 32'h20 || req_valid !== 1'b1 || req_pc !== 32'h38) begin nBad++; $display("FAIL sim_pushpop got %h/%b/%h want 00000020/1/00000038", inst0_pc, req_valid, req_pc); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [5] = '{32'h28, 32'h30, 32'h38, 32'h40, 32'h48};
      for (int i = 0; i < 5; i++) begin
         tick();
         nCmp++; if (inst0_valid !== 1'b1 || inst0_pc !== exp[i]) begin nBad++; $display("FAIL b2b%0d got %b/%h want 1/%h", i, inst0_valid, inst0_pc, exp[i]); end
      end
   endtask

   task automatic test_wrap();
      bit got;
      flush = 1'b1; flush_target = 32'hFFFF_FFFC;
      tick(); flush = 1'b0;
      #1;
      nCmp++; if (req_valid !== 1'b1 || req_pc !== 32'hFFFF_FFFC) begin nBad++; $display("FAIL wrap_req0 got %b/%h want 1/fffffffc", req_valid, req_pc); end
      tick();
      nCmp++; if (req_pc !== 32'h0000_0000) begin nBad++; $display("FAIL wrap_req1 got %h want 00000000", req_pc); end
      waitBundle(got);
      nCmp++; if (!got || inst0_valid !== 1'b0 || inst1_pc !== 32'hFFFF_FFFC || inst0_pc !== 32'hFFFF_FFF8) begin nBad++; $display("FAIL wrap_bundle got %b/%b/%h/%h want 1/0/fffffffc/fffffff8", got, inst0_valid, inst1_pc, inst0_pc); end
      nCmp++; if (inst1_inst !== 32'h2000_FFFC) begin nBad++; $display("FAIL wrap_inst got %h want 2000fffc", inst1_inst); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_flush_drop();
      test_predecode();
      test_pause();
      test_simultaneous();
      test_back_to_back();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
